// File: rtl/matmul_pkg.sv
// ============================================================================
//  Package  : matmul_pkg
//  Purpose  : Shared types and sizing constants for the 2x2 nibble matrix
//             multiplier (FSM state type, operand/result widths, counts).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package matmul_pkg;

   // Controller phases: operand capture, serial multiply, result hand-off
   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   localparam int NIB_W  = 4;  // operand element width
   localparam int N_NIB  = 8;  // nibbles per job: A00..A11, B00..B11
   localparam int N_STEP = 8;  // one product per step, two per C element
   localparam int N_RES  = 4;  // result elements C00, C01, C10, C11
   localparam int RES_W  = 9;  // 15*15 + 15*15 = 450 fits in 9 bits

endpackage : matmul_pkg

`default_nettype wire

// File: rtl/mul4x4_array.sv
// ============================================================================
//  Module   : mul4x4_array
//  Purpose  : Combinational 4x4 -> 8 unsigned array multiplier built from
//             rows of ripple full adders over AND-gate partial products.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mul4x4_array
   import matmul_pkg::*;
(
   input  logic [NIB_W-1:0]   i_a,
   input  logic [NIB_W-1:0]   i_b,
   output logic [2*NIB_W-1:0] o_p
);

   // w_pp[r][c] = a[c] & b[r]  (row r carries weight 2^r)
   logic [3:0][3:0] w_pp;
   // w_row[r-1] is the sum row produced by adder row r (r = 1..3)
   logic [2:0][3:0] w_row;
   // w_cy[r-1][c] is the carry into column c of adder row r
   logic [2:0][4:0] w_cy;
   // w_up[r] is the 4-bit running partial sum passed down to row r+1
   logic [2:0][3:0] w_up;

   genvar gr, gc;

   // Partial-product AND plane
   generate
      for (gr = 0; gr < 4; gr++) begin : g_pp_row
         for (gc = 0; gc < 4; gc++) begin : g_pp_col
            assign w_pp[gr][gc] = i_a[gc] & i_b[gr];
         end
      end
   endgenerate

   // Row 0 contributes its LSB directly; the rest feeds the first adder row
   assign w_up[0] = {1'b0, w_pp[0][3:1]};

   // Adder rows 1..3: each adds one partial-product row to the running sum
   generate
      for (gr = 1; gr < 4; gr++) begin : g_add_row
         assign w_cy[gr-1][0] = 1'b0;
         for (gc = 0; gc < 4; gc++) begin : g_fa
            assign w_row[gr-1][gc] = w_up[gr-1][gc] ^ w_pp[gr][gc] ^ w_cy[gr-1][gc];
            assign w_cy[gr-1][gc+1] = (w_up[gr-1][gc] & w_pp[gr][gc])
                                    | (w_up[gr-1][gc] & w_cy[gr-1][gc])
                                    | (w_pp[gr][gc]   & w_cy[gr-1][gc]);
         end
         if (gr < 3) begin : g_pass
            assign w_up[gr] = {w_cy[gr-1][4], w_row[gr-1][3:1]};
         end
      end
   endgenerate

   // Each row retires one low product bit; the last row supplies the top five
   assign o_p = {w_cy[2][4], w_row[2], w_row[1][0], w_row[0][0], w_pp[0][0]};

endmodule : mul4x4_array

`default_nettype wire

// File: rtl/matmul2x2_seq.sv
// ============================================================================
//  Module   : matmul2x2_seq
//  Purpose  : Sequential 2x2 matrix multiply C = A x B on 4-bit unsigned
//             elements. Operands arrive as eight nibbles, one shared 4x4
//             multiplier performs eight steps, and the four 9-bit results
//             leave over a valid/ready handshake.
//  Options  : MATMUL_JOBCNT_EN - adds the 8-bit wrapping job_count output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module matmul2x2_seq
   import matmul_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             nib_valid,
   input  logic [NIB_W-1:0] nib_data,
   output logic             nib_ready,
   output logic             busy,
   output logic             res_valid,
   output logic [RES_W-1:0] res_data,
   input  logic             res_ready
`ifdef MATMUL_JOBCNT_EN
   ,
   output logic [7:0]       job_count
`endif
);

   state_t             r_state;
   logic [2:0]         r_nib_cnt;
   logic [2:0]         r_k;
   logic [1:0]         r_idx;
   logic [RES_W-1:0]   r_acc;
   logic [NIB_W-1:0]   r_nib [N_NIB];   // 0..3 = A00,A01,A10,A11; 4..7 = B00..B11
   logic [RES_W-1:0]   r_c   [N_RES];
   logic               r_nib_ready;
   logic               r_busy;
   logic               r_res_valid;
   logic [RES_W-1:0]   r_res_data;

   logic [NIB_W-1:0]   w_mul_a;
   logic [NIB_W-1:0]   w_mul_b;
   logic [2*NIB_W-1:0] w_prod;
   logic [RES_W-1:0]   w_sum;

   // Step k: i = k[2], j = k[1], t = k[0]; operands A[i][t] and B[t][j]
   assign w_mul_a = r_nib[{1'b0, r_k[2], r_k[0]}];
   assign w_mul_b = r_nib[{1'b1, r_k[0], r_k[1]}];
   assign w_sum   = r_acc + {1'b0, w_prod};

   mul4x4_array u_mul (
      .i_a (w_mul_a),
      .i_b (w_mul_b),
      .o_p (w_prod)
   );

   // Controller: operand capture, eight multiply steps, result drain
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= LOAD;
         r_nib_cnt   <= '0;
         r_k         <= '0;
         r_idx       <= '0;
         r_acc       <= '0;
         for (int n = 0; n < N_NIB; n++) r_nib[n] <= '0;
         for (int n = 0; n < N_RES; n++) r_c[n]   <= '0;
         r_nib_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               if (nib_valid) begin
                  r_nib[r_nib_cnt] <= nib_data;
                  r_nib_cnt        <= r_nib_cnt + 3'd1;
                  if (r_nib_cnt == 3'(N_NIB - 1)) begin
                     r_state     <= COMPUTE;
                     r_k         <= '0;
                     r_nib_ready <= 1'b0;
                     r_busy      <= 1'b1;
                  end
               end
            end
            COMPUTE: begin
               // Even step starts an element, odd step finishes it into C
               if (!r_k[0]) r_acc          <= {1'b0, w_prod};
               else         r_c[r_k[2:1]]  <= w_sum;
               r_k <= r_k + 3'd1;
               if (r_k == 3'(N_STEP - 1)) begin
                  // C00 was written at step 1, so it is ready to present now
                  r_state     <= DRAIN;
                  r_busy      <= 1'b0;
                  r_res_valid <= 1'b1;
                  r_idx       <= '0;
                  r_res_data  <= r_c[0];
               end
            end
            DRAIN: begin
               if (res_ready) begin
                  if (r_idx == 2'(N_RES - 1)) begin
                     r_state     <= LOAD;
                     r_nib_ready <= 1'b1;
                     r_res_valid <= 1'b0;
                     r_res_data  <= '0;
                  end else begin
                     r_idx      <= r_idx + 2'd1;
                     r_res_data <= r_c[r_idx + 2'd1];
                  end
               end
            end
            default: begin
               r_state     <= LOAD;
               r_nib_cnt   <= '0;
               r_nib_ready <= 1'b1;
               r_busy      <= 1'b0;
               r_res_valid <= 1'b0;
            end
         endcase
      end
   end

   assign nib_ready = r_nib_ready;
   assign busy      = r_busy;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;

`ifdef MATMUL_JOBCNT_EN
   logic       w_job_done;
   logic [7:0] r_job_cnt;

   assign w_job_done = (r_state == DRAIN) && res_ready && (r_idx == 2'(N_RES - 1));

   // Count jobs whose last result was handed off; wraps naturally at 8 bits
   always_ff @(posedge clk) begin
      if (!rst_n)          r_job_cnt <= '0;
      else if (w_job_done) r_job_cnt <= r_job_cnt + 8'd1;
   end

   assign job_count = r_job_cnt;
`endif

endmodule : matmul2x2_seq

`default_nettype wire

// File: doc/matmul2x2_seq.md
MATMUL2X2_SEQ -- requirements
Module: matmul2x2_seq

Interface
REQ-001 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port nib_valid  in  1  operand nibble present.
REQ-004 SHALL have port nib_data  in  4  operand nibble, unsigned.
REQ-005 SHALL have port nib_ready  out  1  block accepts a nibble this cycle.
REQ-006 SHALL have port busy  out  1  multiply sequence in progress.
REQ-007 SHALL have port res_valid  out  1  result element present.
REQ-008 SHALL have port res_data  out  9  result element, unsigned.
REQ-009 SHALL have port res_ready  in  1  consumer accepts the result element.
REQ-010 SHALL have port job_count  out  8  completed-job count; present only with MATMUL_JOBCNT_EN.

Function
REQ-011 SHALL compute C = A x B for 2x2 matrices of 4-bit unsigned elements: C[i][j] = A[i][0]*B[0][j] + A[i][1]*B[1][j].
REQ-012 SHALL implement FSM states LOAD, COMPUTE and DRAIN, with LOAD as the reset state.
REQ-013 SHALL drive nib_ready=1 only in LOAD; nibbles are accepted only on nib_valid&nib_ready, and nib_valid is ignored in other states.
REQ-014 SHALL store accepted nibbles 0..7 in order as A00, A01, A10, A11, B00, B01, B10, B11.
REQ-015 SHALL transition LOAD->COMPUTE on the edge that accepts nibble 7, with the step counter k=0.
REQ-016 SHALL perform one 4x4 multiply per COMPUTE cycle on a single shared multiplier, taking exactly 8 cycles (k=0..7).
REQ-017 SHALL, at step k, use element e=k>>1, i=e>>1, j=e&1 and term t=k&1, with product A[i][t]*B[t][j].
REQ-018 SHALL, when t=0, load the accumulator with the product.
REQ-019 SHALL, when t=1, write the accumulator plus the product into C[e].
REQ-020 SHALL size sums at 9 bits (maximum 450), so no overflow is possible.
REQ-021 SHALL drive busy=1 exactly while in COMPUTE, and SHALL transition COMPUTE->DRAIN on the edge ending k=7.
REQ-022 SHALL, in DRAIN, hold res_valid=1 with res_data=C[idx] for idx=0..3 (C00, C01, C10, C11).
REQ-023 SHALL advance idx on res_valid&res_ready, and SHALL hold res_data stable while res_ready=0.
REQ-024 SHALL transition DRAIN->LOAD on the handshake of idx 3, with nib_ready=1 in the next cycle.
REQ-025 SHALL keep A, B and C registers unchanged outside their write steps, and res_data is don't-care outside DRAIN.

Reset
REQ-026 SHALL, on rst_n=0 at a clock edge and in any state, set state to LOAD and clear the nibble counter, k, idx, accumulator, A, B, C and job_count.
REQ-027 SHALL drive these output values during and immediately after reset: nib_ready=1, busy=0, res_valid=0, res_data=0.
REQ-028 SHALL discard a partial load or computation interrupted by reset, with no result emitted.

Configuration
REQ-029 SHALL, with macro MATMUL_JOBCNT_EN defined, provide the job_count output, incremented on the idx-3 drain handshake and wrapping from 255 to 0.
REQ-030 SHALL, without MATMUL_JOBCNT_EN, omit the job_count port and its counter entirely.

Structure
REQ-031 SHALL place the following in shared package matmul_pkg: the FSM state enum (LOAD, COMPUTE, DRAIN), NIB_W=4, N_NIB=8, N_STEP=8, N_RES=4 and RES_W=9.
REQ-032 SHALL instantiate exactly one sub-module, mul4x4_array: a combinational 4x4->8 unsigned full-adder array multiplier used once per COMPUTE cycle.

Verification
REQ-033 SHALL verify: load A=[[1,0],[0,1]], B=[[3,4],[5,6]] -> res_data sequence 3, 4, 5, 6.
REQ-034 SHALL verify: load all nibbles=15 -> four results each 450 (0x1C2).
REQ-035 SHALL verify: accept nibble 7 at cycle N -> busy=1 in cycles N+1..N+8, res_valid=1 from cycle N+9, nib_ready=0 in cycles N+1 until the final drain handshake.
REQ-036 SHALL verify: hold res_ready=0 for 5 cycles in DRAIN -> res_valid=1 and res_data=C00 constant throughout, then 4 handshakes in 4 cycles with res_ready=1.
REQ-037 SHALL verify: assert rst_n=0 after 5 nibbles, then do a full load of A=[[2,3],[4,5]], B=[[6,7],[8,9]] -> results 36, 41, 64, 73, with no stale data.
REQ-038 SHALL verify: with MATMUL_JOBCNT_EN, 257 back-to-back jobs -> job_count=1, and job_count increments only on the final drain handshake.
